mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one single-beat memory port between the fetch-stage instruction requester (I) and the memory-stage data requester (D).
- Requesters use the core's hold-until-data_ok protocol: valid stays high with stable fields until data_ok pulses.
- Sits between core and the memory/cache interface. Fixed D priority, with a streak limiter so fetch cannot starve.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting before I is forced; legal range 1..15.
TIMEOUT_CYCLES, 256, BUSY-state cycle limit, used only with the optional feature; legal range 2..65535.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_valid  in  1  instruction request
i_addr  in  64  instruction byte address, 4-byte aligned
i_data  out  32  instruction word
i_data_ok  out  1  instruction response pulse
i_err  out  1  instruction timeout flag
d_valid  in  1  data request
d_addr  in  64  data byte address
d_size  in  3  log2 bytes
d_strobe  in  8  byte write enables; 0 = read
d_wdata  in  64  store data
d_rdata  out  64  load data
d_data_ok  out  1  data response pulse
d_err  out  1  data timeout flag
m_valid  out  1  downstream request
m_addr  out  64  downstream address
m_size  out  3  downstream size
m_strobe  out  8  downstream strobes
m_wdata  out  64  downstream store data
m_rdata  in  64  downstream read data
m_ready  in  1  downstream completion, one beat
grant_d  out  1  1 = current owner is D
busy  out  1  transaction outstanding

Behaviour:
- Reset (reset=0, async):
  - State IDLE; streak=0; grant_d=0; timer=0.
  - All m_* request fields are registered and clear to 0; busy=0.
  - Any in-flight downstream transaction is abandoned with no data_ok.
- States:
  - IDLE: m_valid=0.
  - BUSY: m_valid=1; the registered m_* fields stay stable until the cycle after completion.
- IDLE arbitration, evaluated on each rising edge:
  - i_valid & d_valid & streak==MAX_D_STREAK: grant I, streak<=0.
  - d_valid otherwise: grant D; streak<=streak+1 (saturating) if i_valid, else streak<=0.
  - i_valid only: grant I, streak<=0.
  - Neither valid: stay IDLE.
  - On any grant: latch the fields, go to BUSY, set busy=1, set grant_d=owner.
- Request fields latched on grant:
  - I grant: m_addr=i_addr, m_size=3'b010, m_strobe=0, m_wdata=0; also latch i_addr[2] as sel.
  - D grant: d_* fields copied unchanged.
- Timing:
  - Arbitration latency: a request sampled at edge N drives m_valid in cycle N..N+1.
  - Completion happens in any BUSY cycle with m_ready=1. In that same cycle, combinationally:
    - owner's data_ok=1;
    - d_rdata=m_rdata;
    - i_data = sel ? m_rdata[63:32] : m_rdata[31:0].
  - Next edge returns to IDLE with busy=0. The next arbitration is one edge later, so the bubble between transactions is at least 1 cycle.
- Outputs when not completing: data_ok, err and read data for the non-owner (and for all requesters when not completing) are 0.
- Requester drops valid while BUSY (protocol violation): the transaction still completes downstream and data_ok still pulses. Fields are not re-sampled.
- A requester keeping valid high after its data_ok is treated as a new request at the next IDLE arbitration.
- No outstanding-transaction pipelining; at most 1 transaction in flight.
- i_err/d_err are 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit timer clears on BUSY entry and increments each BUSY cycle without m_ready.
  - In the BUSY cycle where timer==TIMEOUT_CYCLES-1 and m_ready=0, the owner gets data_ok=1, err=1, read data=0.
  - Next edge goes to IDLE and m_valid drops.
  - m_ready in the timeout cycle counts as a normal completion (err=0).
- Disabled: no timer logic; err outputs tied 0; BUSY waits indefinitely.

Test Plan:
- D only, d_addr=0x80001000, d_strobe=0xFF, d_wdata=0x1122334455667788, m_ready one cycle after m_valid -> m_* fields match exactly; d_data_ok single pulse; grant_d=1; busy falls next edge.
- I only, i_addr=0x80000004, m_rdata=0xAAAA_BBBB_CCCC_DDDD -> m_size=3'b010, m_strobe=0, i_data=0xAAAABBBB, i_data_ok single pulse.
- I and D held continuously, m_ready immediate, MAX_D_STREAK=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; no grant while busy; at least 1 IDLE cycle between grants.
- Async reset asserted mid-BUSY, with no clock edge -> m_valid=0 and busy=0 immediately; after release with d_valid=1, first grant is D with streak=0.
- With MEM_BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, m_ready never asserted -> d_data_ok=1 and d_err=1 in the 8th BUSY cycle, m_valid=0 next cycle. Repeat with m_ready in the 8th cycle -> d_err=0.
- i_valid dropped mid-BUSY, then m_ready -> i_data_ok still pulses once; state returns to IDLE; no new grant.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester single-beat memory arbiter: fixed data priority with a fetch anti-starvation streak limit.
// Define MEM_BUS_ARB_TIMEOUT_EN to add a BUSY-state watchdog that completes the owner with an error flag.
module mem_bus_arbiter #(
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_data_ok,
    output logic        i_err,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_data_ok,
    output logic        d_err,
    output logic        m_valid,
    output logic [63:0] m_addr,
    output logic [2:0]  m_size,
    output logic [7:0]  m_strobe,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    input  logic        m_ready,
    output logic        grant_d,
    output logic        busy
);

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
        $error("mem_bus_arbiter: MAX_D_STREAK out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

    logic [0:0]  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_q, owner_d;
    logic        sel_q, sel_d;
    logic [63:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] wdata_q, wdata_d;

    logic grant_i, grant_dv, granting;
    logic complete, timeout, finish;

    assign complete = (state_q == BUSY) && m_ready;
    assign finish   = complete || timeout;
    assign granting = (state_q == IDLE) && (grant_i || grant_dv);

    // I wins only when it is the sole requester or D has used up its streak allowance.
    assign grant_i  = i_valid && (!d_valid || (streak_q == STREAK_LIMIT));
    assign grant_dv = d_valid && !grant_i;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        owner_d  = owner_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_dv) begin
                    state_d  = BUSY;
                    owner_d  = 1'b1;
                    addr_d   = d_addr;
                    size_d   = d_size;
                    strobe_d = d_strobe;
                    wdata_d  = d_wdata;
                    if (i_valid) begin
                        streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (grant_i) begin
                    state_d  = BUSY;
                    owner_d  = 1'b0;
                    sel_d    = i_addr[2];
                    addr_d   = i_addr;
                    size_d   = 3'b010;
                    strobe_d = 8'h00;
                    wdata_d  = 64'h0;
                    streak_d = 4'd0;
                end
            end
            BUSY: begin
                if (finish) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
            owner_q  <= 1'b0;
            sel_q    <= 1'b0;
            addr_q   <= 64'h0;
            size_q   <= 3'b000;
            strobe_q <= 8'h00;
            wdata_q  <= 64'h0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timer_q, timer_d;

    // Timer counts BUSY cycles without a response; restarts at every grant.
    always_comb begin
        timer_d = timer_q;
        if (granting) begin
            timer_d = 16'd0;
        end else if ((state_q == BUSY) && !m_ready) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= 16'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timeout = (state_q == BUSY) && !m_ready && (timer_q == TIMER_LAST);
    assign i_err   = timeout && !owner_q;
    assign d_err   = timeout && owner_q;
`else
    assign timeout = 1'b0;
    assign i_err   = 1'b0;
    assign d_err   = 1'b0;
`endif

    assign m_valid  = (state_q == BUSY);
    assign busy     = (state_q == BUSY);
    assign grant_d  = owner_q;
    assign m_addr   = addr_q;
    assign m_size   = size_q;
    assign m_strobe = strobe_q;
    assign m_wdata  = wdata_q;

    // Response data is only forwarded on a genuine completion; a timeout returns zero.
    assign i_data_ok = finish && !owner_q;
    assign d_data_ok = finish && owner_q;
    assign d_rdata   = (complete && owner_q) ? m_rdata : 64'h0;
    assign i_data    = (complete && !owner_q) ? (sel_q ? m_rdata[63:32] : m_rdata[31:0]) : 32'h0;

endmodule
